// File: rtl/smartl_mem_pkg.sv
// Shared definitions for the smartL memory path: controller states,
// default geometry and the byte-enable width derivation.
package smartl_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RDATA = 2'd1,
    MERGE = 2'd2,
    WACK  = 2'd3
  } state_t;

  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_ADDRWIDTH = 10;

  function automatic int be_width(input int datawidth);
    return datawidth / 8;
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Per-lane select between new write data and the word read back from RAM.
module byte_merge
  import smartl_mem_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int BEWIDTH   = be_width(DATAWIDTH)
) (
  input  logic [DATAWIDTH-1:0] i_old,
  input  logic [DATAWIDTH-1:0] i_new,
  input  logic [BEWIDTH-1:0]   i_be,
  output logic [DATAWIDTH-1:0] o_data
);

  genvar gi;
  generate
    for (gi = 0; gi < BEWIDTH; gi++) begin : g_lane
      assign o_data[gi*8 +: 8] = i_be[gi] ? i_new[gi*8 +: 8] : i_old[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/ram_bus_ctrl.sv
// Request-side controller for a single-port synchronous RAM without byte
// enables: full writes pass through, partial writes are read-modify-write.
module ram_bus_ctrl
  import smartl_mem_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int BEWIDTH   = be_width(DATAWIDTH)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [ADDRWIDTH-1:0] ReqAddr,
  input  logic [DATAWIDTH-1:0] ReqWData,
  input  logic [BEWIDTH-1:0]   ReqByteEn,
  output logic                 RspValid,
  output logic [DATAWIDTH-1:0] RspRData,
  output logic [ADDRWIDTH-1:0] RamAddr,
  output logic [DATAWIDTH-1:0] RamDataIn,
  output logic                 RamWriteEnable,
  input  logic [DATAWIDTH-1:0] RamDataOut
);

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDRWIDTH-1:0]   r_addr_q;
  logic [DATAWIDTH-1:0]   r_wdata_q;
  logic [BEWIDTH-1:0]     r_be_q;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_be_full;
  logic                   w_be_none;
  logic [DATAWIDTH-1:0]   w_merged;

  assign ReqReady  = (r_state == IDLE) & ~Rst;
  assign w_accept  = ReqValid & ReqReady;
  assign w_be_full = (ReqByteEn == {BEWIDTH{1'b1}});
  assign w_be_none = (ReqByteEn == '0);

  byte_merge #(
    .DATAWIDTH(DATAWIDTH),
    .BEWIDTH  (BEWIDTH)
  ) u_byte_merge (
    .i_old (RamDataOut),
    .i_new (r_wdata_q),
    .i_be  (r_be_q),
    .o_data(w_merged)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_addr_q  <= '0;
      r_wdata_q <= '0;
      r_be_q    <= '0;
    end else if (w_capture) begin
      r_addr_q  <= ReqAddr;
      r_wdata_q <= ReqWData;
      r_be_q    <= ReqByteEn;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_capture      = 1'b0;
    RamAddr        = r_addr_q;
    RamDataIn      = '0;
    RamWriteEnable = 1'b0;
    RspValid       = 1'b0;
    RspRData       = '0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!ReqWrite) begin
            RamAddr = ReqAddr;
            w_next  = RDATA;
          end else if (w_be_full) begin
            RamAddr        = ReqAddr;
            RamDataIn      = ReqWData;
            RamWriteEnable = 1'b1;
            w_next         = WACK;
          end else if (!w_be_none) begin
            // Read the old word now; it is merged on the next cycle.
            RamAddr   = ReqAddr;
            w_capture = 1'b1;
            w_next    = MERGE;
          end else begin
            w_next = WACK;
          end
        end
      end
      RDATA: begin
        RspValid = 1'b1;
        RspRData = RamDataOut;
        w_next   = IDLE;
      end
      MERGE: begin
        RamAddr        = r_addr_q;
        RamDataIn      = w_merged;
        RamWriteEnable = 1'b1;
        w_next         = WACK;
      end
      WACK: begin
        RspValid = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase

    // Reset masks every output immediately, so an in-flight merge never writes.
    if (Rst) begin
      w_capture      = 1'b0;
      RamAddr        = '0;
      RamDataIn      = '0;
      RamWriteEnable = 1'b0;
      RspValid       = 1'b0;
      RspRData       = '0;
    end
  end

endmodule
